seq_det_ctrl: RTL and testbench

Streaming controller for the serial pattern detector.
- Accepts parallel bytes over a valid/ready handshake and serializes them MSB-first into an internal programmable pattern matcher.
- Counts matches and raises a sticky interrupt at a programmed threshold.
- Sits between a byte-wide producer (UART/register bus) and the detector datapath; supersedes hard-wired detectors such as the fixed 10010 block.

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/seq_det_match.sv | 73 +++++++
 rtl/seq_det_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the streaming serial pattern detector:
//   - state_e      : serializer FSM states (ST_IDLE, ST_SHIFT)
//   - DEF_PATTERN  : pattern loaded at reset (the classic 10010 sequence)
//   - DEF_LEN      : pattern length loaded at reset
//   - len_mask()   : returns a mask with the low 'len' bits set
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [4:0]  DEF_PATTERN = 5'b10010;
  localparam int unsigned DEF_LEN     = 5;

  // Low 'len' bits set; saturates to all ones for len >= 32.
  function automatic logic [31:0] len_mask(input logic [31:0] len);
    if (len >= 32'd32) begin
      return '1;
    end
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// -----------------------------------------------------------------------------
// seq_det_match
// Programmable serial pattern matcher. Collects the incoming bit stream into a
// history register, tracks how many valid bits are in the history (fill),
// compares the newest i_len bits against i_pattern and emits a registered
// one-cycle match pulse the cycle after the final pattern bit.
//
// Ports:
//   clk          in   clock, rising edge
//   i_rst_n      in   asynchronous active-low reset
//   i_bit_valid  in   i_bit is meaningful this cycle
//   i_bit        in   serial bit (newest)
//   i_clr_hist   in   clear history and fill (configuration change)
//   i_pattern    in   pattern, bit[len-1] is the oldest bit
//   i_len        in   active pattern length, already in 1..PAT_W
//   i_overlap    in   1 = keep fill after a hit (overlapping matches)
//   o_match      out  one-cycle match pulse
// -----------------------------------------------------------------------------
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  input  logic             i_clr_hist,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_overlap,
  output logic             o_match
);

  // Only PAT_W-1 old bits need to be stored: together with the incoming bit
  // they form the full PAT_W-bit compare window.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_match;

  logic [PAT_W-1:0] w_hist_next;
  logic [LEN_W-1:0] w_fill_next;
  logic             w_hit;

  assign w_hist_next = {r_hist, i_bit};
  assign w_fill_next = (r_fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : r_fill + LEN_W'(1);
  assign w_hit       = i_bit_valid && (w_fill_next >= i_len) &&
                       (((32'(w_hist_next ^ i_pattern)) & len_mask(32'(i_len))) == 32'd0);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (i_clr_hist) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (i_bit_valid) begin
        r_hist <= w_hist_next[PAT_W-2:0];
        // Without overlap a hit consumes its bits: the next match needs a
        // full pattern length of fresh bits.
        r_fill <= (w_hit && !i_overlap) ? '0 : w_fill_next;
      end
    end
  end

  assign o_match = r_match;

endmodule

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Streaming controller for the serial pattern detector. Accepts bytes over a
// valid/ready handshake, serializes them MSB-first into seq_det_match, counts
// matches (saturating) and raises a sticky threshold interrupt.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   s_valid      in   producer word valid
//   s_data       in   producer word (DATA_W)
//   s_ready      out  controller accepts a word this cycle
//   cfg_we       in   write pattern configuration (IDLE, no handshake only)
//   cfg_pattern  in   pattern bits, bit[len-1] is the first bit
//   cfg_len      in   active pattern length
//   cfg_overlap  in   1 = overlapping matches allowed
//   cfg_thresh   in   interrupt threshold, 0 = irq disabled
//   clr          in   clear match_cnt and irq
//   bit_out      out  current serialized bit
//   bit_valid    out  bit_out meaningful this cycle
//   match        out  one-cycle match pulse
//   match_cnt    out  saturating match count
//   irq          out  sticky threshold interrupt
//   cfg_err      out  (SEQ_DET_CFG_CHK_EN only) rejected configuration write
//
// Build option SEQ_DET_CFG_CHK_EN: when defined, writes with an out-of-range
// length or while busy are rejected and flagged on cfg_err. When undefined,
// out-of-range lengths clamp to PAT_W and busy writes are silently dropped.
// -----------------------------------------------------------------------------
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       s_ready,
  input  logic                       cfg_we,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic [CNT_W-1:0]           cfg_thresh,
  input  logic                       clr,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       irq
`ifdef SEQ_DET_CFG_CHK_EN
  ,
  output logic                       cfg_err
`endif
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_bit_idx;

  logic [PAT_W-1:0]  r_pattern;
  logic [LEN_W-1:0]  r_len;
  logic              r_overlap;
  logic [CNT_W-1:0]  r_thresh;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_irq;

  logic              w_last;
  logic              w_hs;
  logic              w_len_bad;
  logic              w_cfg_ok;
  logic              w_cfg_acc;
  logic [LEN_W-1:0]  w_len_eff;
  logic              w_match;
  logic [CNT_W-1:0]  w_cnt_next;

  // Ready is raised on the last bit of a word too, so a waiting producer
  // reloads the shifter with no bubble between words.
  assign w_last    = (r_state == ST_SHIFT) && (r_bit_idx == IDX_W'(DATA_W - 1));
  assign s_ready   = (r_state == ST_IDLE) || w_last;
  assign w_hs      = s_valid && s_ready;
  assign bit_valid = (r_state == ST_SHIFT);
  assign bit_out   = r_shreg[DATA_W-1];

  assign w_len_bad = (cfg_len == '0) || (cfg_len > LEN_W'(PAT_W));
  // Config may only change while the matcher is quiet and no word is offered.
  assign w_cfg_ok  = (r_state == ST_IDLE) && !s_valid;

`ifdef SEQ_DET_CFG_CHK_EN
  assign w_cfg_acc = cfg_we && w_cfg_ok && !w_len_bad;
  assign w_len_eff = cfg_len;
`else
  assign w_cfg_acc = cfg_we && w_cfg_ok;
  assign w_len_eff = w_len_bad ? LEN_W'(PAT_W) : cfg_len;
`endif

  // Serializer FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_shreg   <= s_data;
            r_bit_idx <= '0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_last) begin
            if (s_valid) begin
              r_shreg   <= s_data;
              r_bit_idx <= '0;
            end else begin
              r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
              r_state <= ST_IDLE;
            end
          end else begin
            r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
            r_bit_idx <= r_bit_idx + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= PAT_W'(DEF_PATTERN);
      r_len     <= LEN_W'(DEF_LEN);
      r_overlap <= 1'b1;
      r_thresh  <= '0;
    end else if (w_cfg_acc) begin
      r_pattern <= cfg_pattern;
      r_len     <= w_len_eff;
      r_overlap <= cfg_overlap;
      r_thresh  <= cfg_thresh;
    end
  end

`ifdef SEQ_DET_CFG_CHK_EN
  logic r_cfg_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_err <= 1'b0;
    end else if (cfg_we) begin
      r_cfg_err <= !w_cfg_acc;
    end else if (clr) begin
      r_cfg_err <= 1'b0;
    end
  end

  assign cfg_err = r_cfg_err;
`endif

  seq_det_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_match (
    .clk         (clk),
    .i_rst_n     (rst),
    .i_bit_valid (bit_valid),
    .i_bit       (bit_out),
    .i_clr_hist  (w_cfg_acc),
    .i_pattern   (r_pattern),
    .i_len       (r_len),
    .i_overlap   (r_overlap),
    .o_match     (w_match)
  );

  assign w_cnt_next = !w_match          ? r_cnt :
                      (r_cnt == '1)     ? r_cnt : r_cnt + CNT_W'(1);

  // Match counter and sticky interrupt; clr wins over a coincident match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if ((r_thresh != '0) && (w_cnt_next >= r_thresh)) begin
        r_irq <= 1'b1;
      end
    end
  end

  assign match     = w_match;
  assign match_cnt = r_cnt;
  assign irq       = r_irq;

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 5;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = '0;
  logic             s_ready;
  logic             cfg_we = 1'b0;
  logic [4:0]       cfg_pattern = '0;
  logic [2:0]       cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [7:0]       cfg_thresh = '0;
  logic             clr = 1'b0;
  logic             bit_out;
  logic             bit_valid;
  logic             match;
  logic [7:0]       match_cnt;
  logic             irq;
`ifdef SEQ_DET_CFG_CHK_EN
  logic             cfg_err;
`endif

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .clr         (clr),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .match       (match),
    .match_cnt   (match_cnt),
    .irq         (irq)
`ifdef SEQ_DET_CFG_CHK_EN
    ,
    .cfg_err     (cfg_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural reference: pending serial bits and recent history as queues.
  logic       bitq[$];
  logic       hq[$];
  logic [4:0] m_pat;
  int         m_len;
  logic       m_ovl;
  int         m_thresh;
  int         m_cnt;
  logic       m_irq;
  logic       m_err;
  logic       e_bv, e_bit, e_rdy, e_match, last_hs;

  logic [7:0] wq[$];
  int         obs_matches;
  int         obs_bv;

  task automatic model_reset();
    bitq.delete();
    hq.delete();
    m_pat = 5'b10010; m_len = 5; m_ovl = 1'b1; m_thresh = 0;
    m_cnt = 0; m_irq = 1'b0; m_err = 1'b0;
    e_bv = 1'b0; e_bit = 1'b0; e_rdy = 1'b1; e_match = 1'b0; last_hs = 1'b0;
  endtask

  function automatic logic model_hit();
    if (hq.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (hq[hq.size()-1-i] !== m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Advance one clock: apply the model for the edge, then sample after it.
  task automatic tick();
    logic hs, acc, hit, bad_len;
    hs      = s_valid && e_rdy;
    bad_len = (cfg_len == 0) || (cfg_len > 5);
    acc     = cfg_we && !e_bv && !s_valid;
`ifdef SEQ_DET_CFG_CHK_EN
    if (cfg_we) m_err = !(acc && !bad_len);
    else if (clr) m_err = 1'b0;
    acc = acc && !bad_len;
`endif
    if (clr) begin
      m_cnt = 0; m_irq = 1'b0;
    end else begin
      if (e_match && m_cnt < 255) m_cnt++;
      if (m_thresh != 0 && m_cnt >= m_thresh) m_irq = 1'b1;
    end
    hit = 1'b0;
    if (e_bv) begin
      hq.push_back(e_bit);
      if (hq.size() > 5) void'(hq.pop_front());
      hit = model_hit();
      if (hit && !m_ovl) hq.delete();
    end
    e_match = hit;
    if (acc) begin
      m_pat = cfg_pattern; m_len = bad_len ? 5 : int'(cfg_len);
      m_ovl = cfg_overlap; m_thresh = int'(cfg_thresh);
      hq.delete();
    end
    if (hs) for (int i = 7; i >= 0; i--) bitq.push_back(s_data[i]);
    last_hs = hs;
    @(posedge clk); #1;
    if (bitq.size() > 0) begin e_bv = 1'b1; e_bit = bitq.pop_front(); end
    else e_bv = 1'b0;
    e_rdy = (bitq.size() == 0);
  endtask

  task automatic cfg_write(input logic [4:0] p, input logic [2:0] l, input logic o, input logic [7:0] t);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_thresh = t;
    cfg_we = 1'b1; s_valid = 1'b0; clr = 1'b0;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic clr_tick();
    clr = 1'b1; s_valid = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  // Streams wq with random gaps, checking every cycle against the model.
  task automatic stream(input string name, input int gap_max, input logic clr_on_match, input logic cfg_in_shift);
    int wi, gap, guard;
    logic done;
    wi = 0; gap = 0; guard = 0; done = 1'b0;
    obs_matches = 0; obs_bv = 0;
    while (!done && guard < 3000) begin
      if (wi < wq.size() && gap == 0) begin s_valid = 1'b1; s_data = wq[wi]; end
      else s_valid = 1'b0;
      clr    = clr_on_match && e_match;
      cfg_we = cfg_in_shift && e_bv;
      tick();
      total++;
      if ({bit_valid, bit_valid & bit_out, s_ready, match, match_cnt, irq} !==
          {e_bv, e_bv & e_bit, e_rdy, e_match, 8'(m_cnt), m_irq}) begin
        bad++;
        $display("FAIL %s cycle: bv/bit/rdy/match/cnt/irq got %b/%b/%b/%b/%0d/%b want %b/%b/%b/%b/%0d/%b",
                 name, bit_valid, bit_out, s_ready, match, match_cnt, irq,
                 e_bv, e_bit, e_rdy, e_match, m_cnt, m_irq);
      end
      if (match) obs_matches++;
      if (bit_valid) obs_bv++;
      if (last_hs) begin
        wi++;
        gap = $urandom_range(0, gap_max);
      end else if (!s_valid && gap > 0) begin
        gap--;
      end
      if (wi >= wq.size() && !e_bv && !e_match && !last_hs) done = 1'b1;
      guard++;
    end
    s_valid = 1'b0; clr = 1'b0; cfg_we = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: words sent %0d of %0d", name, wi, wq.size());
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    model_reset();
    #2;
    total++; if (bit_valid !== 1'b0) begin bad++; $display("FAIL reset_bit_valid got %b want 0", bit_valid); end
    total++; if (s_ready !== 1'b1)   begin bad++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    total++; if (bit_out !== 1'b0)   begin bad++; $display("FAIL reset_bit_out got %b want 0", bit_out); end
    total++; if (match !== 1'b0)     begin bad++; $display("FAIL reset_match got %b want 0", match); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL reset_match_cnt got %0d want 0", match_cnt); end
    total++; if (irq !== 1'b0)       begin bad++; $display("FAIL reset_irq got %b want 0", irq); end
`ifdef SEQ_DET_CFG_CHK_EN
    total++; if (cfg_err !== 1'b0)   begin bad++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_default();
    wq = '{8'h48};
    stream("default", 0, 1'b0, 1'b0);
    total++; if (obs_matches !== 1) begin bad++; $display("FAIL default_pulses got %0d want 1", obs_matches); end
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL default_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_overlap();
    cfg_write(5'b10010, 3'd5, 1'b1, 8'd0);
    clr_tick();
    wq = '{8'h92};
    stream("overlap1", 0, 1'b0, 1'b0);
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL overlap1_cnt got %0d want 2", match_cnt); end
    cfg_write(5'b10010, 3'd5, 1'b0, 8'd0);
    clr_tick();
    stream("overlap0", 0, 1'b0, 1'b0);
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL overlap0_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_back_to_back();
    cfg_write(5'b10010, 3'd5, 1'b1, 8'd0);
    clr_tick();
    wq = '{8'hFF, 8'h12};
    stream("b2b", 0, 1'b0, 1'b0);
    total++; if (obs_bv !== 16) begin bad++; $display("FAIL b2b_bit_cycles got %0d want 16", obs_bv); end
    total++; if (obs_matches !== 1) begin bad++; $display("FAIL b2b_pulses got %0d want 1", obs_matches); end
    cfg_write(5'b10010, 3'd5, 1'b1, 8'd0);
    clr_tick();
    wq = '{8'h01, 8'h20};
    stream("span", 0, 1'b0, 1'b0);
    total++; if (obs_bv !== 16) begin bad++; $display("FAIL span_bit_cycles got %0d want 16", obs_bv); end
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL span_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_thresh();
    cfg_write(5'b10010, 3'd5, 1'b1, 8'd3);
    clr_tick();
    wq = '{8'h48, 8'h48, 8'h48};
    stream("thresh", 1, 1'b0, 1'b0);
    total++; if (match_cnt !== 8'd3) begin bad++; $display("FAIL thresh_cnt got %0d want 3", match_cnt); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL thresh_irq got %b want 1", irq); end
    repeat (3) tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_sticky got %b want 1", irq); end
    clr_tick();
    total++; if ({match_cnt, irq} !== {8'd0, 1'b0}) begin bad++; $display("FAIL clr_cnt_irq got %0d/%b want 0/0", match_cnt, irq); end
    wq = '{8'h48};
    stream("clr_vs_match", 0, 1'b1, 1'b0);
    total++; if (obs_matches !== 1) begin bad++; $display("FAIL clr_vs_match_pulse got %0d want 1", obs_matches); end
    total++; if (match_cnt !== 8'd0) begin bad++; $display("FAIL clr_vs_match_cnt got %0d want 0", match_cnt); end
  endtask

  task automatic test_config();
    cfg_write(5'b00101, 3'd3, 1'b1, 8'd0);
    clr_tick();
    cfg_pattern = 5'b11111; cfg_len = 3'd2; cfg_overlap = 1'b0; cfg_thresh = 8'd1;
    wq = '{8'hA8};
    stream("cfg_in_shift", 0, 1'b0, 1'b1);
    total++; if (match_cnt !== 8'd2) begin bad++; $display("FAIL cfg101_cnt got %0d want 2", match_cnt); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL cfg_busy_thresh irq got %b want 0", irq); end
  endtask

  task automatic test_saturate();
    cfg_write(5'b00001, 3'd1, 1'b1, 8'd0);
    clr_tick();
    wq.delete();
    repeat (33) wq.push_back(8'hFF);
    stream("saturate", 0, 1'b0, 1'b0);
    total++; if (match_cnt !== 8'd255) begin bad++; $display("FAIL saturate_cnt got %0d want 255", match_cnt); end
  endtask

  task automatic test_reset_mid();
    cfg_write(5'b00101, 3'd3, 1'b1, 8'd0);
    wq = '{8'hA8};
    stream("pre_reset", 0, 1'b0, 1'b0);
    s_data = 8'h48; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    total++; if ({bit_valid, s_ready, match_cnt, match, irq} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid bv/rdy/cnt/match/irq got %b/%b/%0d/%b/%b want 0/1/0/0/0",
               bit_valid, s_ready, match_cnt, match, irq);
    end
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    wq = '{8'h48};
    stream("post_reset", 0, 1'b0, 1'b0);
    total++; if (obs_matches !== 1) begin bad++; $display("FAIL post_reset_pulses got %0d want 1", obs_matches); end
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL post_reset_cnt got %0d want 1", match_cnt); end
  endtask

`ifdef SEQ_DET_CFG_CHK_EN
  task automatic test_cfg_err();
    cfg_write(5'b10010, 3'd5, 1'b1, 8'd0);
    cfg_write(5'b00101, 3'd0, 1'b1, 8'd0);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_len0 got %b want 1", cfg_err); end
    clr_tick();
    wq = '{8'h48};
    stream("cfg_err_keep", 0, 1'b0, 1'b0);
    total++; if (match_cnt !== 8'd1) begin bad++; $display("FAIL cfg_err_unchanged cnt got %0d want 1", match_cnt); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_clr got %b want 0", cfg_err); end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      cfg_write(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) clr_tick();
      wq.delete();
      repeat (4) wq.push_back(8'($urandom_range(0, 255)));
      stream("random", 2, 1'b0, 1'b0);
`ifdef SEQ_DET_CFG_CHK_EN
      total++; if (cfg_err !== m_err) begin bad++; $display("FAIL random_cfg_err got %b want %b", cfg_err, m_err); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_back_to_back();
    test_thresh();
    test_config();
    test_saturate();
    test_reset_mid();
`ifdef SEQ_DET_CFG_CHK_EN
    test_cfg_err();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
